regfile_multiport: RTL and testbench

Parametrised general-purpose register file for the pipelined datapath. It replaces the fixed 2-read/1-write, 32×64 file. It adds:
- configurable width, depth and read-port count;
- synchronous reset of every register;
- a hardwired zero register at a configurable index;
- same-cycle write-to-read bypass;
- a per-register pending-write scoreboard that decode uses to detect RAW hazards.

It sits between decode (read/allocate) and writeback (write).

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_rdport.sv | 75 +++++++
 rtl/regfile_multiport.sv | 95 +++++++++
 tb/tb_regfile_multiport.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and index type for the multiport register file.
// Optional same-cycle write-to-read bypass is enabled with REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int unsigned REGFILE_WIDTH = 64;
  localparam int unsigned REGFILE_DEPTH = 32;
  localparam int unsigned REGFILE_ZERO  = 31;
  localparam int unsigned REGFILE_AW    = $clog2(REGFILE_DEPTH);

  typedef logic [$clog2(REGFILE_DEPTH)-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: DEPTH:1 data mux, zero-register force, Pending select.
// With REGFILE_BYPASS_EN defined it also forwards the same-cycle write and masks Pending.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter  int unsigned WIDTH    = REGFILE_WIDTH,
  parameter  int unsigned DEPTH    = REGFILE_DEPTH,
  parameter  int unsigned ZERO_REG = REGFILE_ZERO,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic [DEPTH*WIDTH-1:0] regs,
  input  logic [DEPTH-1:0]       pend,
  input  logic [AW-1:0]          rd_idx,
`ifdef REGFILE_BYPASS_EN
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_idx,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   alloc_en,
  input  logic [AW-1:0]          alloc_idx,
`endif
  output logic [WIDTH-1:0]       rd_data,
  output logic                   pending
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

  logic [WIDTH-1:0] stored;
  logic             is_zero;

  assign is_zero = (rd_idx == ZERO_IDX);

  always_comb begin
    stored = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rd_idx == AW'(i)) begin
        stored = regs[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic wr_hit;
  logic alloc_hit;

  assign wr_hit    = wr_en && (wr_idx == rd_idx) && !is_zero;
  assign alloc_hit = alloc_en && (alloc_idx == rd_idx);

  // A matching write retires the producer this cycle, unless a newer producer
  // is allocated to the same index in the same cycle.
  always_comb begin
    rd_data = stored;
    pending = pend[rd_idx];
    if (wr_hit) begin
      rd_data = wr_data;
      if (!alloc_hit) begin
        pending = 1'b0;
      end
    end
    if (is_zero) begin
      rd_data = '0;
      pending = 1'b0;
    end
  end
`else
  always_comb begin
    rd_data = stored;
    pending = pend[rd_idx];
    if (is_zero) begin
      rd_data = '0;
      pending = 1'b0;
    end
  end
`endif

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file: storage, write decode, pending-write scoreboard, NREAD read ports.
// Define REGFILE_BYPASS_EN to build same-cycle write-to-read forwarding into every port.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter  int unsigned WIDTH    = REGFILE_WIDTH,
  parameter  int unsigned DEPTH    = REGFILE_DEPTH,
  parameter  int unsigned NREAD    = 2,
  parameter  int unsigned ZERO_REG = REGFILE_ZERO,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   RegWrite,
  input  logic [AW-1:0]          WriteRegister,
  input  logic [WIDTH-1:0]       WriteData,
  input  logic [NREAD*AW-1:0]    ReadRegister,
  output logic [NREAD*WIDTH-1:0] ReadData,
  output logic [NREAD-1:0]       Pending,
  input  logic                   AllocEn,
  input  logic [AW-1:0]          AllocRegister
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

  if ((NREAD < 1) || (NREAD > 4) || (ZERO_REG >= DEPTH) || ((1 << AW) != DEPTH) || (DEPTH < 2))
  begin : g_bad_params
    $error("regfile_multiport: illegal parameter combination");
  end

  logic [WIDTH-1:0]       regs_q [DEPTH];
  logic [WIDTH-1:0]       regs_d [DEPTH];
  logic [DEPTH-1:0]       pend_q;
  logic [DEPTH-1:0]       pend_d;
  logic [DEPTH*WIDTH-1:0] regs_flat;

  // Allocation is applied after the write clear so a newer producer wins.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (AW'(i) == ZERO_IDX) begin
        regs_d[i] = '0;
        pend_d[i] = 1'b0;
      end else begin
        if (RegWrite && (WriteRegister == AW'(i))) begin
          regs_d[i] = WriteData;
          pend_d[i] = 1'b0;
        end
        if (AllocEn && (AllocRegister == AW'(i))) begin
          pend_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rdport
    regfile_rdport #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
    ) u_rdport (
      .regs      (regs_flat),
      .pend      (pend_q),
      .rd_idx    (ReadRegister[p*AW +: AW]),
`ifdef REGFILE_BYPASS_EN
      .wr_en     (RegWrite),
      .wr_idx    (WriteRegister),
      .wr_data   (WriteData),
      .alloc_en  (AllocEn),
      .alloc_idx (AllocRegister),
`endif
      .rd_data   (ReadData[p*WIDTH +: WIDTH]),
      .pending   (Pending[p])
    );
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport (4 read ports, 64-bit) with a per-cycle reference model.
// Expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_multiport;

  localparam int unsigned W  = 64;
  localparam int unsigned D  = 32;
  localparam int unsigned NR = 4;
  localparam int unsigned AW = 5;
  localparam logic [AW-1:0] ZR = 5'd31;
  localparam logic [63:0]   K  = 64'h0000010204080001;

  logic              clk = 1'b0;
  logic              reset;
  logic              RegWrite;
  logic [AW-1:0]     WriteRegister;
  logic [W-1:0]      WriteData;
  logic [NR*AW-1:0]  ReadRegister;
  logic [NR*W-1:0]   ReadData;
  logic [NR-1:0]     Pending;
  logic              AllocEn;
  logic [AW-1:0]     AllocRegister;

  int checks = 0;
  int errors = 0;

  regfile_multiport #(
    .WIDTH    (W),
    .DEPTH    (D),
    .NREAD    (NR),
    .ZERO_REG (31)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister  (ReadRegister),
    .ReadData      (ReadData),
    .Pending       (Pending),
    .AllocEn       (AllocEn),
    .AllocRegister (AllocRegister)
  );

  always #5 clk = ~clk;

  // Reference model: architectural contents and outstanding-producer flags.
  logic [W-1:0] mem [D];
  bit           pnd [D];
  bit           model_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(D); i++) begin
        mem[i] = '0;
        pnd[i] = 1'b0;
      end
      model_valid = 1'b1;
    end else begin
      if (RegWrite && WriteRegister != ZR) begin
        mem[WriteRegister] = WriteData;
        pnd[WriteRegister] = 1'b0;
      end
      if (AllocEn && AllocRegister != ZR) pnd[AllocRegister] = 1'b1;
    end
  end

  function automatic logic [W-1:0] exp_data(input logic [AW-1:0] idx);
    if (idx == ZR) return '0;
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && WriteRegister == idx) return WriteData;
`endif
    return mem[idx];
  endfunction

  function automatic logic exp_pend(input logic [AW-1:0] idx);
    if (idx == ZR) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && WriteRegister == idx && !(AllocEn && AllocRegister == idx)) return 1'b0;
`endif
    return pnd[idx];
  endfunction

  function automatic logic [W-1:0] rd(input int p);
    return ReadData[p*W +: W];
  endfunction

  function automatic logic pd(input int p);
    return Pending[p];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid && !reset) begin
      for (int p = 0; p < int'(NR); p++) begin
        logic [AW-1:0] idx;
        idx = ReadRegister[p*AW +: AW];
        chk($sformatf("model_data_p%0d_r%0d", p, idx), rd(p), exp_data(idx));
        chk($sformatf("model_pend_p%0d_r%0d", p, idx), {63'b0, pd(p)}, {63'b0, exp_pend(idx)});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int a, input int b, input int c, input int d);
    ReadRegister = {AW'(d), AW'(c), AW'(b), AW'(a)};
  endtask

  task automatic idle();
    RegWrite = 1'b0;
    AllocEn  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    AllocEn = 1'b0; AllocRegister = '0; set_rd(0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;

    // Write all-ones to r5 and allocate r6, then reset with write+alloc active.
    RegWrite = 1'b1; WriteRegister = 5; WriteData = '1;
    AllocEn = 1'b1; AllocRegister = 6; set_rd(5, 6, 31, 0);
    tick(); idle();
    @(negedge clk);
    chk("pre_reset_r5", rd(0), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pre_reset_pend6", {63'b0, pd(1)}, 64'd1);
    reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5; WriteData = 64'h55;
    AllocEn = 1'b1; AllocRegister = 5;
    tick(); reset = 1'b0; idle();
    @(negedge clk);
    chk("reset_r5", rd(0), 64'h0);
    chk("reset_pending", {60'b0, Pending}, 64'h0);
    tick();

    // Zero register: write and allocate are both dropped.
    RegWrite = 1'b1; WriteRegister = 31; WriteData = 64'hA0;
    AllocEn = 1'b1; AllocRegister = 31; set_rd(31, 31, 31, 31);
    @(negedge clk);
    chk("zero_same_cycle", rd(0), 64'h0);
    tick(); idle();
    @(negedge clk);
    for (int p = 0; p < int'(NR); p++) chk($sformatf("zero_p%0d", p), rd(p), 64'h0);
    chk("zero_pending", {60'b0, Pending}, 64'h0);
    tick();

    // Pattern fill of r0..r30, read back on i, i-1, i, 31.
    for (int i = 0; i < 31; i++) begin
      RegWrite = 1'b1; WriteRegister = AW'(i); WriteData = 64'(i) * K;
      tick();
    end
    idle();
    for (int i = 0; i < 32; i++) begin
      set_rd(i, i - 1, i, 31);
      @(negedge clk);
      chk($sformatf("pattern_r%0d", i), rd(0), (i == 31) ? 64'h0 : 64'(i) * K);
      tick();
    end
    set_rd(30, 7, 3, 20);
    @(negedge clk);
    chk("pattern_r30_lit", rd(0), 64'h00001E3C78F0001E);
    chk("pattern_r7_lit",  rd(1), 64'h0000070E1C380007);
    chk("pattern_r3_lit",  rd(2), 64'h000003060C180003);
    chk("pattern_r20_lit", rd(3), 64'h0000142850A00014);
    tick();

    // Write r7 while reading it in the same cycle.
    RegWrite = 1'b1; WriteRegister = 7; WriteData = 64'h1234; set_rd(7, 8, 7, 31);
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("bypass_same_cycle", rd(0), 64'h1234);
`else
    chk("nobypass_same_cycle", rd(0), 64'h0000070E1C380007);
`endif
    tick(); idle();
    @(negedge clk);
    chk("write_visible_next", rd(0), 64'h1234);
    tick();

    // Scoreboard on r9.
    AllocEn = 1'b1; AllocRegister = 9; set_rd(9, 9, 8, 9);
    @(negedge clk);
    chk("alloc_not_yet", {63'b0, pd(0)}, 64'd0);
    tick(); idle();
    @(negedge clk);
    chk("alloc_pending_p0", {63'b0, pd(0)}, 64'd1);
    chk("alloc_pending_p1", {63'b0, pd(1)}, 64'd1);
    tick();
    RegWrite = 1'b1; WriteRegister = 9; WriteData = 64'h9999;
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("write_mask_same_cycle", {63'b0, pd(0)}, 64'd0);
`else
    chk("write_nomask_same_cycle", {63'b0, pd(0)}, 64'd1);
`endif
    tick(); idle();
    @(negedge clk);
    chk("write_clears_pend", {63'b0, pd(0)}, 64'd0);
    chk("write_r9_data", rd(0), 64'h9999);
    tick();
    AllocEn = 1'b1; AllocRegister = 9;
    tick();
    RegWrite = 1'b1; WriteRegister = 9; WriteData = 64'hBEEF;
    @(negedge clk);
    chk("simul_same_cycle", {63'b0, pd(0)}, 64'd1);
    tick(); idle();
    @(negedge clk);
    chk("simul_pending", {63'b0, pd(0)}, 64'd1);
    chk("simul_data", rd(0), 64'hBEEF);
    tick();

    // Four ports: distinct registers plus two on the same one.
    set_rd(3, 20, 4, 20);
    @(negedge clk);
    chk("mp_p0", rd(0), 64'h000003060C180003);
    chk("mp_p1", rd(1), 64'h0000142850A00014);
    chk("mp_p2", rd(2), 64'h0000040810200004);
    chk("mp_p3", rd(3), 64'h0000142850A00014);
    tick();
    set_rd(9, 3, 9, 31);
    @(negedge clk);
    chk("mp_pending_mix", {60'b0, Pending}, 64'h5);
    tick();

    // Mid-sequence reset discards the outstanding r9 producer.
    reset = 1'b1;
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("midreset_pending", {60'b0, Pending}, 64'h0);
    chk("midreset_r9", rd(0), 64'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
